// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions for the instruction fetch path: datapath width,
// opcode field position, fetch FSM encodings and the buffered entry layout.
package fetch_unit_pkg;

    localparam int XLEN    = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential instruction address; wraps naturally at 2^16.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(2);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; clear empties it and wins over
// push/pop. The caller guarantees no push when full and no pop when empty.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; consumers qualify it with count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one request at a time to instruction memory,
// buffers up to two responses for decode, and squashes in-flight work on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_instr,
    output logic [OPC_W-1:0]  if_opcode,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_pc_plus2
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;

    logic            push, pop;
    fetch_entry_t    push_entry, head;
    logic [1:0]      count;

    fetch_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    // Request is masked during reset so nothing leaks onto the bus while held.
    assign imem_req  = !rst && ((state_q != ST_IDLE) || (count < 2'd2));
    assign imem_addr = (state_q == ST_IDLE) ? fetch_pc_q : req_addr_q;

    assign if_valid    = (count != 2'd0);
    assign if_instr    = if_valid ? head.instr : '0;
    assign if_pc       = if_valid ? head.pc    : '0;
    assign if_opcode   = if_instr[OPC_MSB:OPC_LSB];
    assign if_pc_plus2 = pc_inc(if_pc);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        push_entry = '{pc: imem_addr, instr: imem_rdata};
        pop        = if_valid && if_ready && !redirect_valid;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:1], 1'b0};
            // An unanswered request must still be drained before reissuing.
            if (imem_req && !imem_ack) begin
                state_d    = ST_DROP;
                req_addr_d = imem_addr;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (imem_req) begin
                        if (imem_ack) begin
                            push       = 1'b1;
                            fetch_pc_d = pc_inc(imem_addr);
                        end else begin
                            req_addr_d = fetch_pc_q;
                            state_d    = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        push       = 1'b1;
                        fetch_pc_d = pc_inc(imem_addr);
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule
